nihilist_stream_cipher: RTL

- Sequential, parametrised successor to the combinational Nihilist encrypt block.
- Accepts one ASCII letter per valid/ready handshake and adds its keyed-Polybius code to the code of the current key letter.
- Emits the 8-bit binary sum, e.g. T(44)+D(11) = 55 = 8'b00110111.
- The key is loaded into an internal register file at runtime and repeats cyclically; sits between the text-source stream and the cipher sink.

---
 rtl/nihilist_pkg.sv | 57 +++++
 rtl/nihilist_stream_cipher_polybius.sv | 37 +++
 rtl/nihilist_stream_cipher.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nihilist_pkg.sv
// Shared definitions for the Nihilist stream cipher: keyed Polybius square,
// code width, lookup result type and the letter/code conversion helpers.
package nihilist_pkg;

   localparam int unsigned CODE_W = 8;

   // Row-major 5x5 square; row r / column c (1-based) gives code 10*r + c.
   localparam logic [25*8-1:0] SQUARE = "DANIELBCFGHKMOPQRSTUVWXYZ";

   typedef enum logic {
      MODE_ENC = 1'b0,
      MODE_DEC = 1'b1
   } mode_e;

   typedef struct packed {
      logic              ok;
      logic [CODE_W-1:0] val;
   } lookup_t;

   // Letter stored at linear square position pos (0..24).
   function automatic logic [7:0] square_at(input logic [7:0] pos);
      return SQUARE[{(8'd24 - pos), 3'b000} +: 8];
   endfunction

   // ASCII letter -> Polybius code; lowercase folds to upper, J shares I.
   function automatic lookup_t letter_to_code(input logic [7:0] ch);
      lookup_t    res;
      logic [7:0] c;
      res = '0;
      c   = ch;
      if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
      if (c == 8'h4A) c = 8'h49;
      for (int unsigned i = 0; i < 25; i++) begin
         if (square_at(8'(i)) == c) begin
            res.ok  = 1'b1;
            res.val = CODE_W'((i / 5 + 1) * 10 + (i % 5) + 1);
         end
      end
      return res;
   endfunction

   // Polybius code -> ASCII letter; both decimal digits must be 1..5.
   function automatic lookup_t code_to_letter(input logic [CODE_W-1:0] code);
      lookup_t    res;
      logic [7:0] tens;
      logic [7:0] units;
      res   = '0;
      tens  = code / 8'd10;
      units = code % 8'd10;
      if (tens >= 8'd1 && tens <= 8'd5 && units >= 8'd1 && units <= 8'd5) begin
         res.ok  = 1'b1;
         res.val = square_at((tens - 8'd1) * 8'd5 + units - 8'd1);
      end
      return res;
   endfunction

endpackage

// File: rtl/nihilist_stream_cipher_polybius.sv
// Combinational Polybius lookups: letter -> code always, and code -> letter
// only when NIHILIST_DECRYPT_EN is defined.
module nihilist_polybius
   import nihilist_pkg::*;
(
   input  logic [7:0]        char_in,
   output logic              char_ok,
   output logic [CODE_W-1:0] code_out
`ifdef NIHILIST_DECRYPT_EN
   ,
   input  logic [CODE_W-1:0] code_in,
   output logic              letter_ok,
   output logic [7:0]        letter_out
`endif
);

   lookup_t fwd;

   // Forward lookup of the incoming character.
   always_comb begin
      fwd      = letter_to_code(char_in);
      char_ok  = fwd.ok;
      code_out = fwd.val;
   end

`ifdef NIHILIST_DECRYPT_EN
   lookup_t inv;

   // Inverse lookup of a recovered code.
   always_comb begin
      inv        = code_to_letter(code_in);
      letter_ok  = inv.ok;
      letter_out = inv.val;
   end
`endif

endmodule

// File: rtl/nihilist_stream_cipher.sv
// Nihilist stream cipher: one letter per valid/ready beat, keyed Polybius
// code added to the code of the cyclically repeating runtime key.
// Optional decrypt path guarded by macro NIHILIST_DECRYPT_EN.
module nihilist_stream_cipher
   import nihilist_pkg::*;
#(
   parameter int unsigned P_KEY_MAX = 16,
   parameter int unsigned P_KEY_AW  = $clog2(P_KEY_MAX)
) (
   input  logic                i_w_clk,
   input  logic                i_w_rst_n,
   input  logic                i_w_key_we,
   input  logic [P_KEY_AW-1:0] i_w_key_addr,
   input  logic [7:0]          i_w_key_char,
   input  logic [P_KEY_AW:0]   i_w_key_len,
   input  logic                i_w_mode,
   input  logic                i_w_valid,
   output logic                o_w_ready,
   input  logic                i_w_sof,
   input  logic [7:0]          i_w_data,
   output logic                o_r_valid,
   input  logic                i_w_ready,
   output logic [7:0]          o_r_data,
   output logic                o_r_err
);

   localparam logic [P_KEY_AW:0] KEY_MAX_W = (P_KEY_AW + 1)'(P_KEY_MAX);

   logic [7:0]          key_mem [P_KEY_MAX];
   logic [P_KEY_AW-1:0] key_idx;
   logic [P_KEY_AW:0]   key_len;

   logic                accept;
   logic [P_KEY_AW:0]   len_in;
   logic [P_KEY_AW-1:0] cur_idx;
   logic [P_KEY_AW:0]   cur_len;
   logic [P_KEY_AW:0]   idx_inc;
   logic [P_KEY_AW-1:0] nxt_idx;
   logic [7:0]          key_char;

   logic                text_ok;
   logic [CODE_W-1:0]   text_code;
   logic                key_ok;
   logic [CODE_W-1:0]   key_code;

   logic [7:0]          res_data;
   logic                res_err;
   logic                res_adv;

   assign o_w_ready = !o_r_valid || i_w_ready;
   assign accept    = i_w_valid && o_w_ready;

   // Key length clamp, key slot selection and next index.
   always_comb begin
      if (i_w_key_len == '0)
         len_in = (P_KEY_AW + 1)'(1);
      else if (i_w_key_len > KEY_MAX_W)
         len_in = KEY_MAX_W;
      else
         len_in = i_w_key_len;
      cur_idx  = i_w_sof ? '0 : key_idx;
      cur_len  = i_w_sof ? len_in : key_len;
      key_char = key_mem[cur_idx];
      idx_inc  = {1'b0, cur_idx} + (P_KEY_AW + 1)'(1);
      nxt_idx  = (idx_inc == cur_len) ? '0 : idx_inc[P_KEY_AW-1:0];
   end

`ifdef NIHILIST_DECRYPT_EN
   logic [CODE_W-1:0] diff;
   logic              letter_ok;
   logic [7:0]        letter;
   logic              unused_key_letter_ok;
   logic [7:0]        unused_key_letter;

   assign diff = i_w_data - key_code;

   nihilist_polybius u_text (
      .char_in    (i_w_data),
      .char_ok    (text_ok),
      .code_out   (text_code),
      .code_in    (diff),
      .letter_ok  (letter_ok),
      .letter_out (letter)
   );

   nihilist_polybius u_key (
      .char_in    (key_char),
      .char_ok    (key_ok),
      .code_out   (key_code),
      .code_in    ('0),
      .letter_ok  (unused_key_letter_ok),
      .letter_out (unused_key_letter)
   );
`else
   logic unused_mode;

   assign unused_mode = i_w_mode;

   nihilist_polybius u_text (
      .char_in  (i_w_data),
      .char_ok  (text_ok),
      .code_out (text_code)
   );

   nihilist_polybius u_key (
      .char_in  (key_char),
      .char_ok  (key_ok),
      .code_out (key_code)
   );
`endif

   // Beat result: an invalid text letter holds the key index, a bad key
   // letter (or any decrypt beat) still consumes it.
   always_comb begin
      res_data = '0;
      res_err  = 1'b1;
      res_adv  = 1'b1;
      if (!text_ok) begin
         res_adv = 1'b0;
      end else if (key_ok) begin
         res_data = text_code + key_code;
         res_err  = 1'b0;
      end
`ifdef NIHILIST_DECRYPT_EN
      if (mode_e'(i_w_mode) == MODE_DEC) begin
         res_adv  = 1'b1;
         res_data = '0;
         res_err  = 1'b1;
         if (key_ok && letter_ok) begin
            res_data = letter;
            res_err  = 1'b0;
         end
      end
`endif
   end

   // Output stage and key index/length state.
   always_ff @(posedge i_w_clk) begin
      if (!i_w_rst_n) begin
         o_r_valid <= 1'b0;
         o_r_data  <= '0;
         o_r_err   <= 1'b0;
         key_idx   <= '0;
         key_len   <= (P_KEY_AW + 1)'(1);
      end else if (accept) begin
         o_r_valid <= 1'b1;
         o_r_data  <= res_data;
         o_r_err   <= res_err;
         key_len   <= cur_len;
         key_idx   <= res_adv ? nxt_idx : cur_idx;
      end else if (i_w_ready) begin
         o_r_valid <= 1'b0;
      end
   end

   // Key register file; a same-cycle read sees the previous contents.
   always_ff @(posedge i_w_clk) begin
      if (i_w_key_we && ({1'b0, i_w_key_addr} < KEY_MAX_W))
         key_mem[i_w_key_addr] <= i_w_key_char;
   end

endmodule
